// File: rtl/selector_scan_sequencer.sv
// Address walker feeding the one-hot selector: issues base, base+stride, ...
// for a latched count, advancing only on accepted transfers.
module selector_scan_sequencer #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                xfer;

  assign xfer = en_q & addr_ready;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    en_d        = en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issued_d    = issued_q;
    remaining_d = remaining_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issued_d = '0;
          if (count != '0) begin
            addr_d      = base;
            stride_d    = stride;
            remaining_d = count;
            en_d        = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (xfer) begin
          issued_d    = issued_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end
        // Abort wins over both advancing and completing
        if (abort) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (remaining_q == CNT_W'(1)) begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + stride_q;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issued_q    <= issued_d;
      remaining_q <= remaining_d;
    end
  end

  assign addr   = addr_q;
  assign en     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign issued = issued_q;

endmodule

// File: doc/selector_scan_sequencer.md
Name: selector_scan_sequencer

Overview:
- Upstream address generator for the 12-bit one-hot selector.
- On a start command it walks a programmable run of addresses (base, stride, count) and presents them one at a time on addr/en, advancing only when the selector stage accepts.
- Reports busy while walking, a one-cycle done pulse at completion, and supports abort.

Parameters:
- ADDR_W, 12, address width; the address space is 2**ADDR_W and wraps modulo 2**ADDR_W.
- CNT_W, 13, width of count/remaining; must hold 2**ADDR_W, i.e. a full sweep.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base  input  ADDR_W  first address of the run; latched on accepted start.
- stride  input  ADDR_W  address increment; latched on accepted start; 0 is legal and repeats base.
- count  input  CNT_W  number of addresses to issue; latched on accepted start.
- abort  input  1  terminates a run in progress.
- addr_ready  input  1  downstream selector accepts addr this cycle.
- addr  output  ADDR_W  current address to decode.
- en  output  1  addr valid; drives the selector enable.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a run completes normally.
- issued  output  CNT_W  count of addresses accepted in the current/last run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - addr=0, en=0, busy=0, done=0, issued=0, internal remaining=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and count!=0: latch base/stride/count, set addr<=base, en<=1, busy<=1, issued<=0, remaining<=count. Next state RUN.
  - start=1 and count==0: en stays 0, issued<=0. Next state DONE, so done pulses one cycle after start with nothing issued.
  - abort in IDLE has no effect.
- RUN:
  - Transfer: a transfer occurs on a cycle with en=1 and addr_ready=1.
  - On transfer: issued<=issued+1, remaining<=remaining-1.
    - If remaining==1: en<=0, busy<=0, next state DONE. addr holds its last value.
    - Otherwise: addr<=(addr+stride) mod 2**ADDR_W; en stays 1.
  - No transfer (addr_ready=0): addr and en hold. The address must not change while en=1 and not accepted.
  - abort=1: en<=0, busy<=0, next state IDLE, no done pulse. issued keeps the value including any transfer in this same cycle. abort has priority over advancing addr.
  - start while in RUN is ignored. Latched parameters must not change mid-run.
- DONE:
  - done=1 for exactly this one cycle, then IDLE.
  - A start in this cycle is ignored; it is only sampled in IDLE.
- Throughput: one address per cycle with addr_ready tied high.
  - First addr/en appears 1 cycle after start.
  - done asserts count+1 cycles after the start edge.
- Wrap-around: the address addition truncates to ADDR_W (e.g. 4095+1 -> 0). count=4096 with stride=1 covers every address exactly once.
- Reset mid-run: immediate return to reset values. No done pulse.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then release -> addr=0, en=0, busy=0, done=0, issued=0; start=0 for 10 cycles keeps all outputs at 0.
- Basic run: base=1, stride=1, count=4, addr_ready=1 -> addr sequence 1,2,3,4 on 4 consecutive cycles with en=1; done pulses on cycle 5 after start; issued=4.
- Wrap and stride: base=4094, stride=3, count=3 -> addresses 4094, 1, 4; selector output bit j is 1 and bits j±1 are 0 for each issued address.
- Backpressure: base=12, stride=1, count=3, addr_ready toggled 1,0,0,1,1 -> addr holds 13 through both stall cycles; accepted sequence 12,13,14; issued=3; done after the last acceptance.
- Abort and zero-count:
  - Abort case: count=10, abort asserted after 2 transfers -> en=0 and busy=0 next cycle, no done, issued=2.
  - Zero-count case: start with count=0 -> en never asserts; done pulses 1 cycle after start.
- Async reset mid-run plus random runs:
  - rst_n pulsed low for half a cycle during RUN -> outputs are 0 immediately.
  - 10 random (base, stride, count≤20) runs match a reference model of addresses and done timing.
